// File: rtl/stream_dedup_filter.sv
// Streaming duplicate filter: forwards a word only if it is absent from a sliding
// window of the last DEPTH unique words. Optional macro DEDUP_STATS_EN enables dup_count.
module stream_dedup_filter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  localparam int FILL_W = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [FILL_W-1:0] fill,
  output logic [CNT_W-1:0]  dup_count
);

  logic [WIDTH-1:0]  hist_data_r [DEPTH];
  logic [DEPTH-1:0]  hist_vld_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [FILL_W-1:0] fill_r;
  logic              out_valid_r;
  logic [WIDTH-1:0]  out_data_r;

  logic [DEPTH-1:0]  match_s;
  logic              hit_s;
  logic              accept_s;
  logic              store_s;
  logic [PTR_W-1:0]  wr_idx_s;
  logic [PTR_W-1:0]  next_ptr_s;
  logic [FILL_W-1:0] base_fill_s;
  logic [FILL_W-1:0] next_fill_s;

  assign in_ready  = !out_valid_r || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign store_s   = accept_s && !hit_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign fill      = fill_r;

  // Parallel window lookup; a same-cycle clear makes the window look empty.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = hist_vld_r[i] && (hist_data_r[i] == in_data);
    end
    if (clear) begin
      hit_s       = 1'b0;
      wr_idx_s    = '0;
      base_fill_s = '0;
    end else begin
      hit_s       = |match_s;
      wr_idx_s    = wr_ptr_r;
      base_fill_s = fill_r;
    end
    if (wr_idx_s == PTR_W'(DEPTH - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = wr_idx_s + PTR_W'(1);
    end
    if (base_fill_s == FILL_W'(DEPTH)) begin
      next_fill_s = base_fill_s;
    end else begin
      next_fill_s = base_fill_s + FILL_W'(1);
    end
  end

  // History window: flush on clear, then store a unique word at the write slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld_r <= '0;
      wr_ptr_r   <= '0;
      fill_r     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_data_r[i] <= '0;
      end
    end else begin
      if (clear) begin
        hist_vld_r <= '0;
        wr_ptr_r   <= '0;
        fill_r     <= '0;
      end
      if (store_s) begin
        hist_data_r[wr_idx_s] <= in_data;
        hist_vld_r[wr_idx_s]  <= 1'b1;
        wr_ptr_r              <= next_ptr_s;
        fill_r                <= next_fill_s;
      end
    end
  end

`ifdef DEDUP_STATS_EN
  logic [CNT_W-1:0] dup_cnt_r;

  // Saturating count of dropped repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      dup_cnt_r <= '0;
    end else if (clear) begin
      dup_cnt_r <= '0;
    end else if (accept_s && hit_s && (dup_cnt_r != {CNT_W{1'b1}})) begin
      dup_cnt_r <= dup_cnt_r + CNT_W'(1);
    end
  end

  assign dup_count = dup_cnt_r;
`else
  assign dup_count = CNT_W'(0);
`endif

  // Output register: load a unique word, otherwise retire a consumed beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (store_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= in_data;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule
